// File: rtl/wb_stage.sv
// MEM/WB pipeline register plus write-back selection: load extraction, link handling,
// write-enable qualification, sticky misaligned-load flag and retired-instruction counter.
module wb_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        in_valid,
    input  logic        in_regwrite,
    input  logic        in_memtoreg,
    input  logic        in_link,
    input  logic [4:0]  in_dest,
    input  logic [31:0] in_alu_result,
    input  logic [31:0] in_mem_data,
    input  logic [2:0]  in_load_type,
    input  logic [31:0] in_pc4,
    output logic [4:0]  reg_write,
    output logic        regwrite_con,
    output logic [31:0] write_data,
    output logic        wb_valid,
    output logic        align_err,
    output logic [31:0] retired
);

    logic        valid_q, valid_d;
    logic        regwrite_q, regwrite_d;
    logic        memtoreg_q, memtoreg_d;
    logic        link_q, link_d;
    logic [4:0]  dest_q, dest_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] mem_q, mem_d;
    logic [2:0]  ltype_q, ltype_d;
    logic [31:0] pc4_q, pc4_d;
    logic        align_err_q, align_err_d;
    logic [31:0] retired_q, retired_d;
    logic        misaligned;

    // Big-endian lanes: offset 0 is the most significant byte/halfword.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  off,
                                                 input logic [2:0]  ltype);
        logic signed [7:0]  sb;
        logic signed [15:0] sh;
        logic [31:0]        r;
        case (off)
            2'd0:    sb = word[31:24];
            2'd1:    sb = word[23:16];
            2'd2:    sb = word[15:8];
            default: sb = word[7:0];
        endcase
        sh = off[1] ? word[15:0] : word[31:16];
        case (ltype)
            3'd1:    r = 32'(sb);
            3'd2:    r = {24'b0, sb};
            3'd3:    r = 32'(sh);
            3'd4:    r = {16'b0, sh};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic misaligned_load(input logic       mtr,
                                             input logic [2:0] ltype,
                                             input logic [1:0] off);
        logic m;
        case (ltype)
            3'd1, 3'd2: m = 1'b0;
            3'd3, 3'd4: m = off[0];
            default:    m = (off != 2'd0);
        endcase
        return mtr & m;
    endfunction

    assign misaligned   = misaligned_load(memtoreg_q, ltype_q, alu_q[1:0]);
    assign reg_write    = link_q ? 5'd31 : dest_q;
    assign regwrite_con = valid_q & regwrite_q & (reg_write != 5'd0) & ~misaligned;
    assign write_data   = link_q     ? pc4_q :
                          memtoreg_q ? load_extract(mem_q, alu_q[1:0], ltype_q) :
                                       alu_q;
    assign wb_valid     = valid_q;
    assign align_err    = align_err_q;
    assign retired      = retired_q;

    always_comb begin
        valid_d     = valid_q;
        regwrite_d  = regwrite_q;
        memtoreg_d  = memtoreg_q;
        link_d      = link_q;
        dest_d      = dest_q;
        alu_d       = alu_q;
        mem_d       = mem_q;
        ltype_d     = ltype_q;
        pc4_d       = pc4_q;
        // Flush only kills the valid bit; the payload stays so a bubble is cheap.
        if (flush) begin
            valid_d = 1'b0;
        end else if (!stall) begin
            valid_d    = in_valid;
            regwrite_d = in_regwrite;
            memtoreg_d = in_memtoreg;
            link_d     = in_link;
            dest_d     = in_dest;
            alu_d      = in_alu_result;
            mem_d      = in_mem_data;
            ltype_d    = in_load_type;
            pc4_d      = in_pc4;
        end
        align_err_d = align_err_q | (valid_q & misaligned);
        retired_d   = retired_q + {31'b0, valid_q & ~stall};
    end

    // alu_q is cleared so write_data reads zero while rst is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= 1'b0;
            regwrite_q  <= 1'b0;
            memtoreg_q  <= 1'b0;
            link_q      <= 1'b0;
            dest_q      <= 5'd0;
            alu_q       <= 32'd0;
            align_err_q <= 1'b0;
            retired_q   <= 32'd0;
        end else begin
            valid_q     <= valid_d;
            regwrite_q  <= regwrite_d;
            memtoreg_q  <= memtoreg_d;
            link_q      <= link_d;
            dest_q      <= dest_d;
            alu_q       <= alu_d;
            align_err_q <= align_err_d;
            retired_q   <= retired_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q   <= mem_d;
        ltype_q <= ltype_d;
        pc4_q   <= pc4_d;
    end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: random traffic against a rule-level reference model, then directed scenarios.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush, in_valid, in_regwrite, in_memtoreg, in_link;
    logic [4:0]  in_dest;
    logic [31:0] in_alu_result, in_mem_data, in_pc4;
    logic [2:0]  in_load_type;
    logic [4:0]  reg_write;
    logic        regwrite_con, wb_valid, align_err;
    logic [31:0] write_data, retired;

    int checks = 0;
    int errors = 0;

    // Reference model: the instruction currently sitting in WB plus the two counters.
    logic        m_valid, m_rw, m_mtr, m_link, m_aerr;
    logic [4:0]  m_dest;
    logic [31:0] m_alu, m_mem, m_pc4, m_ret, saved_ret;
    logic [2:0]  m_lt;

    wb_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg),
        .in_link(in_link), .in_dest(in_dest), .in_alu_result(in_alu_result),
        .in_mem_data(in_mem_data), .in_load_type(in_load_type), .in_pc4(in_pc4),
        .reg_write(reg_write), .regwrite_con(regwrite_con), .write_data(write_data),
        .wb_valid(wb_valid), .align_err(align_err), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic e_mis();
        int off = int'(m_alu % 4);
        if (!m_mtr) return 1'b0;
        if (m_lt == 3'd1 || m_lt == 3'd2) return 1'b0;
        if (m_lt == 3'd3 || m_lt == 3'd4) return (off % 2) == 1;
        return off != 0;
    endfunction

    function automatic logic [4:0] e_rw();
        return m_link ? 5'd31 : m_dest;
    endfunction

    function automatic logic e_con();
        return m_valid && m_rw && (e_rw() != 5'd0) && !e_mis();
    endfunction

    function automatic logic [31:0] e_wd();
        int unsigned off = m_alu % 4;
        int unsigned b   = (m_mem >> (8 * (3 - off))) % 256;
        int unsigned h   = (off >= 2) ? (m_mem % 65536) : (m_mem / 65536);
        if (m_link) return m_pc4;
        if (!m_mtr) return m_alu;
        case (m_lt)
            3'd1:    return (b >= 128) ? 32'(b) - 32'd256 : 32'(b);
            3'd2:    return 32'(b);
            3'd3:    return (h >= 32768) ? 32'(h) - 32'd65536 : 32'(h);
            3'd4:    return 32'(h);
            default: return m_mem;
        endcase
    endfunction

    task automatic m_reset();
        m_valid = 0; m_rw = 0; m_mtr = 0; m_link = 0; m_dest = 0;
        m_alu = 0; m_aerr = 0; m_ret = 0;
    endtask

    task automatic drive(input logic v, input logic rw, input logic mtr, input logic lk,
                         input logic [4:0] d, input logic [31:0] alu, input logic [31:0] mem,
                         input logic [2:0] lt, input logic [31:0] pc4,
                         input logic st, input logic fl);
        in_valid = v; in_regwrite = rw; in_memtoreg = mtr; in_link = lk; in_dest = d;
        in_alu_result = alu; in_mem_data = mem; in_load_type = lt; in_pc4 = pc4;
        stall = st; flush = fl;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".wb_valid"}, 32'(wb_valid), 32'(m_valid));
        chk({tag, ".reg_write"}, 32'(reg_write), 32'(e_rw()));
        chk({tag, ".regwrite_con"}, 32'(regwrite_con), 32'(e_con()));
        chk({tag, ".align_err"}, 32'(align_err), 32'(m_aerr));
        chk({tag, ".retired"}, retired, m_ret);
        if (e_con()) chk({tag, ".write_data"}, write_data, e_wd());
    endtask

    // One clock: model applies the edge rules to the inputs held across it.
    task automatic step(input string tag);
        @(posedge clk);
        if (m_valid && !stall) m_ret = m_ret + 1;
        if (m_valid && e_mis()) m_aerr = 1'b1;
        if (flush) m_valid = 1'b0;
        else if (!stall) begin
            m_valid = in_valid; m_rw = in_regwrite; m_mtr = in_memtoreg; m_link = in_link;
            m_dest = in_dest; m_alu = in_alu_result; m_mem = in_mem_data;
            m_lt = in_load_type; m_pc4 = in_pc4;
        end
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 3'd0, 32'd0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        m_reset();
        #1;
        chk("reset.regwrite_con", 32'(regwrite_con), 32'd0);
        chk("reset.wb_valid", 32'(wb_valid), 32'd0);
        chk("reset.reg_write", 32'(reg_write), 32'd0);
        chk("reset.write_data", write_data, 32'd0);
        chk("reset.align_err", 32'(align_err), 32'd0);
        chk("reset.retired", retired, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 200; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
                  ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31)),
                  $urandom, $urandom, 3'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
            step("rand");
        end

        // Asynchronous reset between edges.
        idle();
        #2 rst = 1'b1;
        m_reset();
        #1;
        chk("rst_async.retired", retired, 32'd0);
        chk("rst_async.align_err", 32'(align_err), 32'd0);
        chk("rst_async.wb_valid", 32'(wb_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        drive(1, 1, 1, 0, 5'd9, 32'h1001, 32'h12F45678, 3'd1, 32'd0, 0, 0);
        step("lb");
        chk("lb.reg_write", 32'(reg_write), 32'd9);
        chk("lb.write_data", write_data, 32'hFFFFFFF4);
        chk("lb.regwrite_con", 32'(regwrite_con), 32'd1);

        drive(1, 1, 1, 0, 5'd5, 32'h2002, 32'hAAAA8001, 3'd4, 32'd0, 0, 0);
        step("lhu");
        chk("lhu.write_data", write_data, 32'h00008001);
        drive(1, 1, 1, 0, 5'd6, 32'h2001, 32'hAAAA8001, 3'd3, 32'd0, 0, 0);
        step("lh_mis");
        chk("lh_mis.regwrite_con", 32'(regwrite_con), 32'd0);
        drive(1, 1, 0, 0, 5'd7, 32'h10, 32'd0, 3'd0, 32'd0, 0, 0);
        step("after_mis1");
        chk("after_mis1.align_err", 32'(align_err), 32'd1);
        drive(1, 1, 0, 0, 5'd8, 32'h20, 32'd0, 3'd0, 32'd0, 0, 0);
        step("after_mis2");
        chk("after_mis2.align_err", 32'(align_err), 32'd1);

        drive(1, 1, 0, 1, 5'd0, 32'h77, 32'd0, 3'd0, 32'h00400008, 0, 0);
        step("jal");
        chk("jal.reg_write", 32'(reg_write), 32'd31);
        chk("jal.write_data", write_data, 32'h00400008);
        chk("jal.regwrite_con", 32'(regwrite_con), 32'd1);
        drive(1, 1, 0, 0, 5'd0, 32'h99, 32'd0, 3'd0, 32'd0, 0, 0);
        step("alu_x0");
        chk("alu_x0.regwrite_con", 32'(regwrite_con), 32'd0);
        saved_ret = m_ret;
        idle();
        step("alu_x0_retire");
        chk("alu_x0.retired_inc", retired, saved_ret + 32'd1);

        drive(1, 1, 0, 0, 5'd3, 32'h55, 32'd0, 3'd0, 32'd0, 0, 0);
        step("alu55");
        chk("alu55.write_data", write_data, 32'h55);
        saved_ret = m_ret;
        drive(1, 1, 0, 0, 5'd4, 32'hAA, 32'd0, 3'd0, 32'd0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step("stall");
            chk("stall.write_data", write_data, 32'h55);
            chk("stall.reg_write", 32'(reg_write), 32'd3);
            chk("stall.retired_hold", retired, saved_ret);
        end
        idle();
        step("unstall");
        chk("unstall.retired_inc", retired, saved_ret + 32'd1);
        drive(1, 1, 0, 0, 5'd3, 32'h66, 32'd0, 3'd0, 32'd0, 0, 0);
        step("pre_flush");
        drive(1, 1, 0, 0, 5'd4, 32'h67, 32'd0, 3'd0, 32'd0, 1, 1);
        step("flush_stall");
        chk("flush_stall.wb_valid", 32'(wb_valid), 32'd0);

        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 0, 0, 5'(i + 10), 32'(i), 32'd0, 3'd0, 32'd0, 0, 0);
            step("stream");
        end
        drive(1, 1, 0, 0, 5'd20, 32'h5, 32'd0, 3'd0, 32'd0, 1, 0);
        step("stream_stall");
        #2 rst = 1'b1;
        m_reset();
        #1;
        chk("rst_mid.regwrite_con", 32'(regwrite_con), 32'd0);
        chk("rst_mid.retired", retired, 32'd0);
        chk("rst_mid.write_data", write_data, 32'd0);
        @(negedge clk);
        idle();
        rst = 1'b0;
        step("post_rst");
        chk("post_rst.retired", retired, 32'd0);

        drive(1, 1, 0, 0, 5'd2, 32'h1, 32'd0, 3'd0, 32'd0, 0, 0);
        step("wrap_load");
        force dut.retired_q = 32'hFFFFFFFF;
        #1 release dut.retired_q;
        m_ret = 32'hFFFFFFFF;
        chk("wrap.preload", retired, 32'hFFFFFFFF);
        idle();
        step("wrap");
        chk("wrap.retired", retired, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
